// File: rtl/uart_tx_arbiter.sv
// Four-requester byte arbiter feeding a single UART transmitter.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_WAIT  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req_en,
  input  logic [31:0] req_data,
  output logic [3:0]  pending,
  output logic [3:0]  req_drop,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [1:0]  tx_src,
  input  logic        tx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

  localparam int CW = 16;
  localparam int BW_EFF = (BUSY_WAIT > 0) ? BUSY_WAIT : 1;
  localparam int GP_EFF = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam logic [CW-1:0] BW_LAST = CW'(BW_EFF - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GP_EFF - 1);
  localparam state_e DONE_NEXT = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][7:0] slot_q, slot_d;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      drop_q, drop_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      src_q, src_d;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      idx;
`endif

  logic [1:0] win;
  logic       found;
  logic [3:0] gnt;

  always_comb begin
    win   = 2'd0;
    found = |pending_q;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) begin
      if (pending_q[k]) win = 2'(k);
    end
`else
    idx = 2'd0;
    // Descending scan so the nearest requester after the pointer wins.
    for (int k = 3; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (pending_q[idx]) win = idx;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    src_d   = src_q;
    start_d = 1'b0;
    gnt     = 4'd0;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt     = 4'd1 << win;
          data_d  = slot_q[win];
          src_d   = win;
          start_d = 1'b1;
          state_d = START;
`ifndef UART_ARB_FIXED_PRIO_EN
          rr_d    = win + 2'd1;
`endif
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == BW_LAST) begin
          cnt_d   = '0;
          state_d = DONE_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = DONE_NEXT;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    drop_d = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (req_en[i] && (!pending_q[i] || gnt[i]))
        slot_d[i] = req_data[8*i +: 8];
      drop_d[i] = req_en[i] & pending_q[i] & ~gnt[i];
    end
    pending_d = req_en | (pending_q & ~gnt);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      slot_q    <= '0;
      pending_q <= 4'd0;
      drop_q    <= 4'd0;
      start_q   <= 1'b0;
      data_q    <= 8'd0;
      src_q     <= 2'd0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_q      <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      start_q   <= start_d;
      data_q    <= data_d;
      src_q     <= src_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign pending  = pending_q;
  assign req_drop = drop_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign tx_src   = src_q;

endmodule
